alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational RV32I ALU (funct3/funct7 decode; adder, comparator and shifter result buses) between two requesters, e.g. the execute stage and the address/branch-target unit.
- Round-robin arbitration with a valid/ready request channel and a valid/ready response channel per requester.
- Latches operands, drives the ALU, waits a configurable settle time, then returns the correctly selected result bus to the winning requester.

Parameters:
- XLEN, 32, operand/result width; must match the ALU.
- ALU_LATENCY, 1, cycles operands are held on the ALU before capture (legal range 1 to 15).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid / req1_valid  input  1  requester i presents an operation
- req0_ready / req1_ready  output  1  arbiter accepts requester i this cycle
- req0_op1 / req1_op1  input  XLEN  operand 1 of requester i
- req0_op2 / req1_op2  input  XLEN  operand 2 of requester i
- req0_funct3 / req1_funct3  input  3  RV32I funct3 of requester i
- req0_funct7 / req1_funct7  input  1  funct7 bit 5 (sub/sra select) of requester i
- resp0_valid / resp1_valid  output  1  result for requester i is available
- resp0_ready / resp1_ready  input  1  requester i consumes the result
- resp0_result / resp1_result  output  XLEN  result for requester i
- alu_op1  output  XLEN  ALU operand 1
- alu_op2  output  XLEN  ALU operand 2
- alu_funct3  output  3  ALU funct3
- alu_funct7  output  1  ALU funct7 bit
- alu_adder_rsv  input  XLEN  ALU adder/logic result
- alu_comparator_rsv  input  XLEN  ALU slt/sltu result
- alu_shifter_rsv  input  XLEN  ALU sll/srl/sra result
- grant_id  output  1  requester currently owning the ALU; valid in EXEC and RESP

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst); no asynchronous reset anywhere.
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values:
  - all resp*_valid = 0, all resp*_result = 0;
  - all alu_* outputs = 0;
  - grant_id = 0, last_grant = 1 (so requester 0 wins the first conflict), latency counter = 0.
- IDLE:
  - req*_ready is combinational from req*_valid and last_grant. At most one ready is high; ready is never high outside IDLE.
  - One valid: that requester is readied.
  - Both valid: the requester != last_grant is readied.
  - Accept on valid && ready: latch op1, op2, funct3 and funct7 into internal registers; grant_id <= winner; last_grant <= winner; counter <= 0; next state EXEC.
  - No valid: stay in IDLE.
- EXEC:
  - alu_* outputs are driven from the latched registers, stable for the entire state.
  - Counter increments each cycle. After ALU_LATENCY cycles in EXEC, capture the selected result and go to RESP.
  - Result select by latched funct3:
    - 001 or 101 -> alu_shifter_rsv;
    - 010 or 011 -> alu_comparator_rsv;
    - 000, 100, 110, 111 -> alu_adder_rsv.
- RESP:
  - resp[grant_id]_valid = 1; the other resp valid = 0; resp[grant_id]_result holds the captured value.
  - On resp_ready = 1: back to IDLE; valid drops the next cycle.
  - While ready = 0: hold valid and result unchanged indefinitely.
  - alu_* outputs continue to hold the latched values.
- Latency: accept in cycle N -> resp_valid first high in cycle N+1+ALU_LATENCY.
  - A new accept is possible in the cycle after the response handshake.
  - Minimum spacing between accepts is ALU_LATENCY+2 cycles.
- Boundaries:
  - A requester that drops valid before being readied is simply not served; no state change.
  - The non-granted requester waits; its inputs are ignored until IDLE.
  - Operand changes after accept have no effect on an in-flight operation.
  - Width rule: result is passed through unmodified; no sign/zero extension inside this block.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded with no response; all outputs and last_grant return to their reset values the next cycle.

Test Plan:
- Single op: req0 add op1=100, op2=100, funct3=000, funct7=0, accept in cycle 0 -> resp0_valid in cycle 2 with resp0_result=200; resp1_valid stays 0; alu_op1=100 during EXEC.
- Conflict and fairness: after reset, both valid in the same cycle, req0 sub 100-100 (funct7=1), req1 sll 1 by 4 (funct3=001):
  - req0 is served first, resp0_result=0; req1 is served next, resp1_result=16;
  - a third simultaneous conflict grants req0 again (last_grant was 1).
- Backpressure: hold resp0_ready=0 for 5 cycles -> resp0_valid and resp0_result are constant; req0_ready and req1_ready stay 0; completion occurs only on the ready cycle.
- Result select:
  - slt 0xFFFFFFFF vs 1 (funct3=010) -> 1;
  - sra 0x80000000 by 4 (funct3=101, funct7=1) -> 0xF8000000;
  - xor 100 ^ 100 -> 0.
- Reset during EXEC -> next cycle resp*_valid=0 and alu_op1=0; no response is ever issued for that op; the next conflict grants req0.
- ALU_LATENCY=3 build: accept in cycle 0 -> resp_valid first in cycle 4; alu_* stable for cycles 1-3.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational RV32I ALU between two requesters
module alu_share_arbiter #(
  parameter int XLEN        = 32,
  parameter int ALU_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_op1,
  input  logic [XLEN-1:0] req0_op2,
  input  logic [2:0]      req0_funct3,
  input  logic            req0_funct7,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_op1,
  input  logic [XLEN-1:0] req1_op2,
  input  logic [2:0]      req1_funct3,
  input  logic            req1_funct7,
  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic [XLEN-1:0] resp0_result,
  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp1_result,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [2:0]      alu_funct3,
  output logic            alu_funct7,
  input  logic [XLEN-1:0] alu_adder_rsv,
  input  logic [XLEN-1:0] alu_comparator_rsv,
  input  logic [XLEN-1:0] alu_shifter_rsv,
  output logic            grant_id
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] LAST_CNT = 4'(ALU_LATENCY - 1);

  state_t          state;
  logic            last_grant;
  logic [3:0]      lat_cnt;
  logic [XLEN-1:0] sel_result;
  logic            resp_done;

  // On a conflict the requester that did not win last time is readied.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE) begin
      req0_ready = req0_valid && (!req1_valid || last_grant);
      req1_ready = req1_valid && (!req0_valid || !last_grant);
    end
  end

  always_comb begin
    sel_result = alu_adder_rsv;
    case (alu_funct3)
      3'b001, 3'b101: sel_result = alu_shifter_rsv;
      3'b010, 3'b011: sel_result = alu_comparator_rsv;
      default:        sel_result = alu_adder_rsv;
    endcase
  end

  assign resp_done = grant_id ? resp1_ready : resp0_ready;

  // The alu_* registers double as the operand latch, so they stay stable through EXEC and RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant_id     <= 1'b0;
      lat_cnt      <= 4'd0;
      alu_op1      <= '0;
      alu_op2      <= '0;
      alu_funct3   <= 3'b000;
      alu_funct7   <= 1'b0;
      resp0_valid  <= 1'b0;
      resp1_valid  <= 1'b0;
      resp0_result <= '0;
      resp1_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            alu_op1    <= req0_op1;
            alu_op2    <= req0_op2;
            alu_funct3 <= req0_funct3;
            alu_funct7 <= req0_funct7;
            grant_id   <= 1'b0;
            last_grant <= 1'b0;
            lat_cnt    <= 4'd0;
            state      <= EXEC;
          end else if (req1_ready) begin
            alu_op1    <= req1_op1;
            alu_op2    <= req1_op2;
            alu_funct3 <= req1_funct3;
            alu_funct7 <= req1_funct7;
            grant_id   <= 1'b1;
            last_grant <= 1'b1;
            lat_cnt    <= 4'd0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          lat_cnt <= lat_cnt + 4'd1;
          if (lat_cnt == LAST_CNT) begin
            state <= RESP;
            if (grant_id) begin
              resp1_valid  <= 1'b1;
              resp1_result <= sel_result;
            end else begin
              resp0_valid  <= 1'b1;
              resp0_result <= sel_result;
            end
          end
        end
        RESP: begin
          if (resp_done) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_op1 = 0, req0_op2 = 0, req1_op1 = 0, req1_op2 = 0;
  logic [2:0]  req0_funct3 = 0, req1_funct3 = 0;
  logic        req0_funct7 = 0, req1_funct7 = 0;
  logic        resp0_valid, resp1_valid, resp0_ready = 0, resp1_ready = 0;
  logic [31:0] resp0_result, resp1_result;
  logic [31:0] alu_op1, alu_op2, alu_adder_rsv, alu_comparator_rsv, alu_shifter_rsv;
  logic [2:0]  alu_funct3;
  logic        alu_funct7, grant_id;

  logic        l3_req0_valid = 0, l3_req0_ready, l3_req1_ready;
  logic [31:0] l3_req0_op1 = 0, l3_req0_op2 = 0;
  logic        l3_resp0_valid, l3_resp1_valid, l3_resp0_ready = 0;
  logic [31:0] l3_resp0_result, l3_resp1_result;
  logic [31:0] l3_alu_op1, l3_alu_op2, l3_adder, l3_comparator, l3_shifter;
  logic [2:0]  l3_alu_funct3;
  logic        l3_alu_funct7, l3_grant_id;

  int n_assert = 0;
  int n_fail   = 0;
  bit last     = 1'b1;

  // Behavioural ALU feeding the three result buses.
  function automatic logic [31:0] adder_bus(logic [2:0] f3, logic f7, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'b100:  return a ^ b;
      3'b110:  return a | b;
      3'b111:  return a & b;
      3'b000:  if (f7) return a - b; else return a + b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] comparator_bus(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    if (f3 == 3'b011) return {31'b0, a < b};
    return {31'b0, $signed(a) < $signed(b)};
  endfunction

  function automatic logic [31:0] shifter_bus(logic [2:0] f3, logic f7, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] s;
    s = a;
    if (!f3[2]) return a << b[4:0];
    if (f7) return s >>> b[4:0];
    return a >> b[4:0];
  endfunction

  // Architectural RV32I result the requester expects back.
  function automatic logic [31:0] ref_op(logic [2:0] f3, logic f7, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] s;
    s = a;
    case (f3)
      3'd0: return f7 ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: if (f7) return s >>> b[4:0]; else return a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_adder_rsv      = adder_bus(alu_funct3, alu_funct7, alu_op1, alu_op2);
  assign alu_comparator_rsv = comparator_bus(alu_funct3, alu_op1, alu_op2);
  assign alu_shifter_rsv    = shifter_bus(alu_funct3, alu_funct7, alu_op1, alu_op2);
  assign l3_adder           = adder_bus(l3_alu_funct3, l3_alu_funct7, l3_alu_op1, l3_alu_op2);
  assign l3_comparator      = comparator_bus(l3_alu_funct3, l3_alu_op1, l3_alu_op2);
  assign l3_shifter         = shifter_bus(l3_alu_funct3, l3_alu_funct7, l3_alu_op1, l3_alu_op2);

  alu_share_arbiter #(.XLEN(32), .ALU_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req0_funct3(req0_funct3), .req0_funct7(req0_funct7),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2),
    .req1_funct3(req1_funct3), .req1_funct7(req1_funct7),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_adder_rsv(alu_adder_rsv), .alu_comparator_rsv(alu_comparator_rsv),
    .alu_shifter_rsv(alu_shifter_rsv), .grant_id(grant_id)
  );

  alu_share_arbiter #(.XLEN(32), .ALU_LATENCY(3)) dut_l3 (
    .clk(clk), .rst(rst),
    .req0_valid(l3_req0_valid), .req0_ready(l3_req0_ready), .req0_op1(l3_req0_op1), .req0_op2(l3_req0_op2),
    .req0_funct3(3'b000), .req0_funct7(1'b0),
    .req1_valid(1'b0), .req1_ready(l3_req1_ready), .req1_op1(32'd0), .req1_op2(32'd0),
    .req1_funct3(3'b000), .req1_funct7(1'b0),
    .resp0_valid(l3_resp0_valid), .resp0_ready(l3_resp0_ready), .resp0_result(l3_resp0_result),
    .resp1_valid(l3_resp1_valid), .resp1_ready(1'b0), .resp1_result(l3_resp1_result),
    .alu_op1(l3_alu_op1), .alu_op2(l3_alu_op2), .alu_funct3(l3_alu_funct3), .alu_funct7(l3_alu_funct7),
    .alu_adder_rsv(l3_adder), .alu_comparator_rsv(l3_comparator),
    .alu_shifter_rsv(l3_shifter), .grant_id(l3_grant_id)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit i, input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input bit f7);
    if (i) begin
      req1_valid = v; req1_op1 = a; req1_op2 = b; req1_funct3 = f3; req1_funct7 = f7;
    end else begin
      req0_valid = v; req0_op1 = a; req0_op2 = b; req0_funct3 = f3; req0_funct7 = f7;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last = 1'b1;
  endtask

  // Accept the expected winner, scramble its inputs, then run EXEC and RESP with a stall.
  task automatic run_op(input bit win, input int stall);
    logic [31:0] exp, op1;
    #1;
    chk("ready0", req0_ready, win == 1'b0);
    chk("ready1", req1_ready, win == 1'b1);
    op1 = win ? req1_op1 : req0_op1;
    exp = win ? ref_op(req1_funct3, req1_funct7, req1_op1, req1_op2)
              : ref_op(req0_funct3, req0_funct7, req0_op1, req0_op2);
    last = win;
    tick();
    set_req(win, 1'b1, $urandom, $urandom, 3'($urandom), 1'($urandom));
    chk("exec_grant", grant_id, win);
    chk("exec_op1", alu_op1, op1);
    chk("exec_resp", {resp0_valid, resp1_valid}, 0);
    chk("exec_ready", {req0_ready, req1_ready}, 0);
    tick();
    for (int s = 0; s <= stall; s++) begin
      chk("resp_valid", {resp0_valid, resp1_valid}, win ? 2'b01 : 2'b10);
      chk("resp_result", win ? resp1_result : resp0_result, exp);
      chk("resp_ready_low", {req0_ready, req1_ready}, 0);
      chk("resp_op1", alu_op1, op1);
      if (win) begin resp1_ready = (s == stall); resp0_ready = 1'b1; end
      else     begin resp0_ready = (s == stall); resp1_ready = 1'b1; end
      tick();
    end
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    set_req(win, 1'b0, 0, 0, 0, 0);
    #1;
    chk("resp_drop", {resp0_valid, resp1_valid}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit v0, v1, w;
    tick();
    do_reset();
    #1;
    chk("rst_resp_valid", {resp0_valid, resp1_valid}, 0);
    chk("rst_result0", resp0_result, 0);
    chk("rst_result1", resp1_result, 0);
    chk("rst_alu", {alu_op1 | alu_op2, 29'd0, alu_funct3}, 0);
    chk("rst_f7_grant", {alu_funct7, grant_id}, 0);
    chk("rst_idle_ready", {req0_ready, req1_ready}, 0);

    // Single add.
    set_req(0, 1, 100, 100, 3'b000, 0);
    run_op(0, 0);

    // Conflict after reset: req0 sub first, req1 sll next, then req0 again.
    do_reset();
    set_req(0, 1, 100, 100, 3'b000, 1);
    set_req(1, 1, 1, 4, 3'b001, 0);
    run_op(0, 5);
    chk("sub_value", resp0_result, 0);
    run_op(1, 0);
    chk("sll_value", resp1_result, 16);
    set_req(0, 1, 7, 3, 3'b110, 0);
    set_req(1, 1, 9, 9, 3'b111, 0);
    run_op(0, 0);
    set_req(1, 0, 0, 0, 0, 0);

    // Result-select directed cases.
    set_req(1, 1, 32'hFFFF_FFFF, 1, 3'b010, 0);
    run_op(1, 1);
    chk("slt_value", resp1_result, 1);
    set_req(0, 1, 32'h8000_0000, 4, 3'b101, 1);
    run_op(0, 0);
    chk("sra_value", resp0_result, 32'hF800_0000);
    set_req(1, 1, 100, 100, 3'b100, 0);
    run_op(1, 2);
    chk("xor_value", resp1_result, 0);

    // Reset while EXEC: the op vanishes and arbitration history is cleared.
    set_req(1, 1, 5, 6, 3'b000, 0);
    tick();
    set_req(1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last = 1'b1;
    chk("midrst_resp", {resp0_valid, resp1_valid}, 0);
    chk("midrst_op1", alu_op1, 0);
    for (int k = 0; k < 4; k++) begin
      chk("midrst_noresp", {resp0_valid, resp1_valid}, 0);
      tick();
    end
    set_req(0, 1, 3, 4, 3'b011, 0);
    set_req(1, 1, 3, 4, 3'b000, 0);
    run_op(0, 0);
    set_req(1, 0, 0, 0, 0, 0);

    // Randomized rounds against the round-robin model.
    for (int r = 0; r < 40; r++) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) begin
        #1;
        chk("idle_no_ready", {req0_ready, req1_ready}, 0);
        v0 = 1'b1;
      end
      set_req(0, v0, $urandom, $urandom, 3'($urandom), 1'($urandom));
      set_req(1, v1, $urandom, $urandom, 3'($urandom), 1'($urandom));
      w = (v0 && v1) ? !last : !v0;
      run_op(w, $urandom_range(0, 3));
      set_req(!w, 0, 0, 0, 0, 0);
    end

    // Latency-3 instance: accept in cycle 0, response in cycle 4.
    l3_req0_valid = 1; l3_req0_op1 = 5; l3_req0_op2 = 7;
    #1;
    chk("l3_ready", l3_req0_ready, 1);
    tick();
    l3_req0_valid = 0;
    for (int k = 1; k <= 3; k++) begin
      chk("l3_exec_valid", l3_resp0_valid, 0);
      chk("l3_exec_ops", {l3_alu_op1[15:0], l3_alu_op2[15:0]}, {16'd5, 16'd7});
      l3_req0_op1 = $urandom;
      tick();
    end
    chk("l3_resp_valid", l3_resp0_valid, 1);
    chk("l3_resp_result", l3_resp0_result, 12);
    chk("l3_resp1_valid", l3_resp1_valid, 0);
    l3_resp0_ready = 1;
    tick();
    l3_resp0_ready = 0;
    chk("l3_resp_drop", l3_resp0_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
